// File: rtl/nf10_param_output_queues.sv
// Parameterised output-queue block.
//
// One AXI4-Stream ingress is fanned out to C_NUM_QUEUES egress queues. The
// destination bitmap is taken from tuser on the first beat of each packet. A
// queue accepts the packet only if it has more than C_MAX_PKT_WORDS free words.
// Packets nobody can accept are dropped, never backpressured. A packet that
// outgrows its reservation is cut short with a forced tlast.
//
// Ports:
//   axi_aclk, axi_reset    : clock, synchronous active-high reset
//   s_axis_*               : ingress stream (tready is 1 whenever not in reset)
//   m_axis_*               : egress streams, queue i occupies slice i
//   drop_count             : per-queue saturating dropped-packet counters (32b each)
module nf10_param_output_queues #(
  parameter int unsigned C_DATA_WIDTH    = 256,
  parameter int unsigned C_TUSER_WIDTH   = 128,
  parameter int unsigned C_NUM_QUEUES    = 5,
  parameter int unsigned C_DEPTH_BITS    = 9,
  parameter int unsigned C_MAX_PKT_WORDS = 64,
  parameter int unsigned C_DST_OFFSET    = 24
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_reset,
  input  logic [C_DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]              s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]               s_axis_tuser,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  output logic [C_NUM_QUEUES*C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_NUM_QUEUES*C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_NUM_QUEUES*C_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic [C_NUM_QUEUES-1:0]                m_axis_tvalid,
  output logic [C_NUM_QUEUES-1:0]                m_axis_tlast,
  input  logic [C_NUM_QUEUES-1:0]                m_axis_tready,
  output logic [32*C_NUM_QUEUES-1:0]             drop_count
);

  localparam int unsigned StrbW = C_DATA_WIDTH / 8;
  localparam int unsigned WordW = 1 + StrbW + C_TUSER_WIDTH + C_DATA_WIDTH;
  localparam int unsigned Depth = 2 ** C_DEPTH_BITS;
  localparam int unsigned CntW  = C_DEPTH_BITS + 1;

  localparam logic [CntW-1:0]         Capacity = CntW'(Depth);
  localparam logic [CntW-1:0]         MaxWords = CntW'(C_MAX_PKT_WORDS);
  localparam logic [CntW-1:0]         CntOne   = CntW'(1);
  localparam logic [C_DEPTH_BITS-1:0] PtrOne   = C_DEPTH_BITS'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StDrop} state_e;

  state_e                  r_state, w_state_next;
  logic [C_NUM_QUEUES-1:0] r_admit, w_admit_next;
  logic [C_NUM_QUEUES-1:0] w_dst, w_ok, w_cur_admit, w_drop_first;
  logic [C_NUM_QUEUES-1:0] w_wr_en, w_trunc, w_drop_inc;
  logic [CntW-1:0]         w_free [C_NUM_QUEUES];
  logic                    w_beat;

  assign s_axis_tready = ~axi_reset;
  assign w_beat        = s_axis_tvalid & ~axi_reset;
  assign w_dst         = s_axis_tuser[C_DST_OFFSET +: C_NUM_QUEUES];

  // Ingress FSM: decides per beat which queues take a copy.
  always_comb begin
    w_state_next = r_state;
    w_admit_next = r_admit;
    w_cur_admit  = '0;
    w_drop_first = '0;
    w_trunc      = '0;
    if (w_beat) begin
      case (r_state)
        StIdle: begin
          w_cur_admit  = w_dst & w_ok;
          w_drop_first = w_dst & ~w_ok;
          if (s_axis_tlast) begin
            w_state_next = StIdle;
          end else if (|w_cur_admit) begin
            w_state_next = StWrite;
          end else begin
            w_state_next = StDrop;
          end
        end
        StWrite: begin
          w_cur_admit = r_admit;
          if (s_axis_tlast) w_state_next = StIdle;
        end
        StDrop: begin
          if (s_axis_tlast) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
    // Last free slot on a non-final beat: close the packet in that queue early.
    for (int i = 0; i < int'(C_NUM_QUEUES); i++) begin
      w_trunc[i] = w_cur_admit[i] & ~s_axis_tlast & (w_free[i] == CntOne);
    end
    if (w_beat && (r_state != StDrop)) begin
      w_admit_next = w_cur_admit & ~w_trunc;
    end
  end

  assign w_wr_en    = w_cur_admit;
  assign w_drop_inc = w_drop_first | w_trunc;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state <= StIdle;
      r_admit <= '0;
    end else begin
      r_state <= w_state_next;
      r_admit <= w_admit_next;
    end
  end

  for (genvar gi = 0; gi < int'(C_NUM_QUEUES); gi++) begin : g_queue
    logic [WordW-1:0]        r_mem [Depth];
    logic [C_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0]         r_count;
    logic                    r_out_valid;
    logic [WordW-1:0]        r_out_word;
    logic [31:0]             r_drop;
    logic                    w_push, w_pop, w_load;
    logic [WordW-1:0]        w_in_word;

    // The output-stage word counts as occupied.
    assign w_free[gi] = Capacity - r_count - CntW'(r_out_valid);
    assign w_ok[gi]   = (w_free[gi] > MaxWords);

    assign w_in_word = {s_axis_tlast | w_trunc[gi], s_axis_tstrb, s_axis_tuser, s_axis_tdata};
    assign w_push    = w_wr_en[gi] & (w_free[gi] != '0);
    assign w_pop     = r_out_valid & m_axis_tready[gi];
    // Refill the output stage whenever it is empty or being drained this cycle.
    assign w_load    = (r_count != '0) & (~r_out_valid | w_pop);

    always_ff @(posedge axi_aclk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_word;
    end

    always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
        r_out_word  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
        if (w_load) r_rd_ptr <= r_rd_ptr + PtrOne;
        case ({w_push, w_load})
          2'b10:   r_count <= r_count + CntOne;
          2'b01:   r_count <= r_count - CntOne;
          default: r_count <= r_count;
        endcase
        if (w_load) begin
          r_out_word  <= r_mem[r_rd_ptr];
          r_out_valid <= 1'b1;
        end else if (w_pop) begin
          r_out_valid <= 1'b0;
        end
      end
    end

    always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
        r_drop <= '0;
      end else if (w_drop_inc[gi] && (r_drop != '1)) begin
        r_drop <= r_drop + 32'd1;
      end
    end

    assign m_axis_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH]    = r_out_word[0 +: C_DATA_WIDTH];
    assign m_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH]  =
      r_out_word[C_DATA_WIDTH +: C_TUSER_WIDTH];
    assign m_axis_tstrb[gi*StrbW +: StrbW]                  =
      r_out_word[C_DATA_WIDTH + C_TUSER_WIDTH +: StrbW];
    assign m_axis_tlast[gi]                                 = r_out_word[WordW-1];
    assign m_axis_tvalid[gi]                                = r_out_valid;
    assign drop_count[gi*32 +: 32]                          = r_drop;
  end

endmodule

// File: tb/tb_nf10_param_output_queues.sv
// Bench for nf10_param_output_queues: directed packets, per-queue expected-word
// scoreboard and an independent monitor that pops on every egress handshake.
module tb_nf10_param_output_queues;
  localparam int NQ   = 5;
  localparam int DW   = 32;
  localparam int UW   = 32;
  localparam int SW   = DW / 8;
  localparam int DB   = 3;
  localparam int MAXW = 4;
  localparam int OFF  = 24;
  localparam int WW   = 1 + SW + UW + DW;

  logic              clk = 1'b0;
  logic              axi_reset = 1'b1;
  logic [DW-1:0]     s_axis_tdata = '0;
  logic [SW-1:0]     s_axis_tstrb = '0;
  logic [UW-1:0]     s_axis_tuser = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [NQ*DW-1:0]  m_axis_tdata;
  logic [NQ*SW-1:0]  m_axis_tstrb;
  logic [NQ*UW-1:0]  m_axis_tuser;
  logic [NQ-1:0]     m_axis_tvalid;
  logic [NQ-1:0]     m_axis_tlast;
  logic [NQ-1:0]     m_axis_tready = '1;
  logic [32*NQ-1:0]  drop_count;

  nf10_param_output_queues #(
    .C_DATA_WIDTH   (DW),
    .C_TUSER_WIDTH  (UW),
    .C_NUM_QUEUES   (NQ),
    .C_DEPTH_BITS   (DB),
    .C_MAX_PKT_WORDS(MAXW),
    .C_DST_OFFSET   (OFF)
  ) dut (
    .axi_aclk     (clk),
    .axi_reset    (axi_reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            exp_wr [NQ];
  int            exp_rd [NQ];
  logic [WW-1:0] exp_mem [NQ][64];
  logic          stalled [NQ];
  logic [WW-1:0] held [NQ];
  int            pkt_id = 1;
  logic          rand_mode = 1'b0;
  logic [NQ-1:0] fixed_ready = '1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int q, input logic [WW-1:0] w);
    exp_mem[q][exp_wr[q] % 64] = w;
    exp_wr[q]++;
  endtask

  function automatic logic all_empty();
    for (int q = 0; q < NQ; q++) if (exp_wr[q] != exp_rd[q]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic busy(input logic [NQ-1:0] d);
    for (int q = 0; q < NQ; q++) if (d[q] && (exp_wr[q] - exp_rd[q] > 3)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_beat(input logic [NQ-1:0] dst, input int b, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(pkt_id * 256 + b) ^ 32'hA500_0000;
    s_axis_tuser  = {3'b000, dst, 24'(pkt_id * 16 + b)};
    s_axis_tstrb  = SW'(b + 1);
    s_axis_tlast  = last;
  endtask

  // Drives an nb-beat packet; queues in exp_mask expect the first `keep` beats,
  // the last kept one carrying tlast.
  task automatic send_pkt(input logic [NQ-1:0] dst, input int nb, input logic [NQ-1:0] exp_mask,
                          input int keep);
    for (int b = 0; b < nb; b++) begin
      @(posedge clk); #1;
      drive_beat(dst, b, b == nb - 1);
      for (int q = 0; q < NQ; q++) begin
        if (exp_mask[q] && b < keep) begin
          push(q, {(b == nb - 1) || (b == keep - 1), s_axis_tstrb, s_axis_tuser, s_axis_tdata});
        end
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pkt_id++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!all_empty() && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (!all_empty()) begin
      errors++;
      $display("FAIL drain_timeout got outstanding words expected none after %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_drops(input string name, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
    logic [31:0] e [NQ];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int q = 0; q < NQ; q++) begin
      chk($sformatf("%s_drop%0d", name, q), 64'(drop_count[q*32 +: 32]), 64'(e[q]));
    end
  endtask

  // Egress ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rand_mode ? NQ'($urandom) : fixed_ready;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic [WW-1:0] got;
    for (int q = 0; q < NQ; q++) stalled[q] = 1'b0;
    forever begin
      @(negedge clk);
      for (int q = 0; q < NQ; q++) begin
        got = {m_axis_tlast[q], m_axis_tstrb[q*SW +: SW], m_axis_tuser[q*UW +: UW],
               m_axis_tdata[q*DW +: DW]};
        if (axi_reset) begin
          stalled[q] = 1'b0;
        end else begin
          if (stalled[q]) begin
            checks++;
            if (!m_axis_tvalid[q] || got !== held[q]) begin
              errors++;
              $display("FAIL hold_q%0d got v=%0b %h expected v=1 %h", q, m_axis_tvalid[q], got,
                       held[q]);
            end
          end
          if (m_axis_tvalid[q] && m_axis_tready[q]) begin
            checks++;
            if (exp_rd[q] == exp_wr[q]) begin
              errors++;
              $display("FAIL unexpected_q%0d got %h expected no output", q, got);
            end else begin
              if (got !== exp_mem[q][exp_rd[q] % 64]) begin
                errors++;
                $display("FAIL data_q%0d got %h expected %h", q, got, exp_mem[q][exp_rd[q] % 64]);
              end
              exp_rd[q]++;
            end
          end
          stalled[q] = m_axis_tvalid[q] & ~m_axis_tready[q];
          held[q]    = got;
        end
      end
    end
  end

  initial begin
    for (int q = 0; q < NQ; q++) begin
      exp_wr[q] = 0;
      exp_rd[q] = 0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_drops("rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    axi_reset = 1'b0;
    @(negedge clk);
    chk("run_tready", 64'(s_axis_tready), 64'd1);

    // Unicast to queue 2, with latency check on tvalid[2].
    fork
      send_pkt(5'b00100, 3, 5'b00100, 3);
      begin
        @(posedge clk); #1;
        @(negedge clk); chk("lat_c0", 64'(m_axis_tvalid[2]), 64'd0);
        @(negedge clk); chk("lat_c1", 64'(m_axis_tvalid[2]), 64'd0);
        @(negedge clk); chk("lat_c2", 64'(m_axis_tvalid[2]), 64'd1);
      end
    join
    drain(100);

    // Multicast to queues 0, 1, 4.
    send_pkt(5'b10011, 3, 5'b10011, 3);
    drain(100);

    // Admission drop: fill queue 1 until free == C_MAX_PKT_WORDS.
    fixed_ready = 5'b11101;
    repeat (2) @(posedge clk);
    send_pkt(5'b00010, 4, 5'b00010, 4);
    send_pkt(5'b00010, 3, 5'b00000, 0);
    chk_drops("adm1", 0, 1, 0, 0, 0);
    send_pkt(5'b00011, 3, 5'b00001, 3);
    chk_drops("adm2", 0, 2, 0, 0, 0);
    fixed_ready = '1;
    drain(200);

    // Truncation: 10 beats into a stalled, empty queue 0 of depth 8.
    fixed_ready = 5'b11110;
    repeat (2) @(posedge clk);
    send_pkt(5'b00001, 10, 5'b00001, 8);
    chk_drops("trunc", 1, 2, 0, 0, 0);
    send_pkt(5'b00100, 2, 5'b00100, 2);
    send_pkt(5'b00001, 2, 5'b00000, 0);
    chk_drops("full", 2, 2, 0, 0, 0);
    @(negedge clk);
    chk("full_tvalid0", 64'(m_axis_tvalid[0]), 64'd1);
    fixed_ready = '1;
    drain(200);

    // Reset mid-packet after beat 2 of 5.
    fixed_ready = '0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1; drive_beat(5'b01000, 0, 1'b0);
    @(posedge clk); #1; drive_beat(5'b01000, 1, 1'b0);
    @(posedge clk); #1; axi_reset = 1'b1; drive_beat(5'b01000, 2, 1'b0);
    @(posedge clk); #1; drive_beat(5'b01000, 3, 1'b0);
    @(negedge clk);
    chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_drops("mid_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1; drive_beat(5'b01000, 4, 1'b1);
    @(posedge clk); #1;
    axi_reset     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pkt_id++;
    fixed_ready = '1;
    repeat (2) @(posedge clk);
    send_pkt(5'b01000, 2, 5'b01000, 2);
    drain(100);

    // Random egress backpressure; admission is kept guaranteed so nothing drops.
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      logic [NQ-1:0] d;
      int            nb;
      int            n;
      d  = NQ'($urandom_range(1, 31));
      nb = $urandom_range(1, 4);
      n  = 0;
      while (busy(d) && n < 400) begin
        @(posedge clk);
        n++;
      end
      checks++;
      if (busy(d)) begin
        errors++;
        $display("FAIL rand_wait got queue still busy expected drained within 400 cycles");
      end
      send_pkt(d, nb, d, nb);
    end
    drain(2000);
    rand_mode = 1'b0;
    chk_drops("rand", 0, 0, 0, 0, 0);

    for (int q = 0; q < NQ; q++) begin
      chk($sformatf("final_q%0d", q), 64'(exp_rd[q]), 64'(exp_wr[q]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
